// File: rtl/lsu_pkg.sv
// Shared types and lane constants for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    MEM_WORD = 2'b00,
    MEM_BYTE = 2'b01,
    MEM_HALF = 2'b10
  } mem_type_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ1,
    S_WAIT1,
    S_REQ2,
    S_WAIT2,
    S_RESP
  } lsu_state_t;

  localparam logic [3:0] LANES_BYTE = 4'b0001;
  localparam logic [3:0] LANES_HALF = 4'b0011;
  localparam logic [3:0] LANES_WORD = 4'b1111;

  // Encoding 2'b11 has no enum member; it is folded into word accesses.
  function automatic mem_type_t norm_type(input logic [1:0] t);
    if (t == 2'b11) return MEM_WORD;
    return mem_type_t'(t);
  endfunction

  function automatic logic [3:0] lanes_of(input mem_type_t t);
    case (t)
      MEM_BYTE: return LANES_BYTE;
      MEM_HALF: return LANES_HALF;
      default:  return LANES_WORD;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: per-beat byte enables and write data,
// split detection, and load-data merge with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  mem_type_t               i_type,
  input  logic [1:0]              i_offset,
  input  logic                    i_unsigned,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  input  logic [DATA_WIDTH-1:0]   i_beat1,
  input  logic [DATA_WIDTH-1:0]   i_beat2,
  output logic                    o_split,
  output logic [3:0]              o_be1,
  output logic [3:0]              o_be2,
  output logic [DATA_WIDTH-1:0]   o_wdata1,
  output logic [DATA_WIDTH-1:0]   o_wdata2,
  output logic [DATA_WIDTH-1:0]   o_load
);

  logic [7:0]              w_be_wide;
  logic [2*DATA_WIDTH-1:0] w_wdata_wide;
  logic [2*DATA_WIDTH-1:0] w_raw_wide;
  logic [DATA_WIDTH-1:0]   w_raw;
  logic                    w_sext;

  // Shifting into a double-width vector yields beat 1 in the low half and
  // the spill-over for beat 2 in the high half.
  always_comb begin
    w_be_wide    = {4'b0000, lanes_of(i_type)} << i_offset;
    w_wdata_wide = {{DATA_WIDTH{1'b0}}, i_wdata} << {i_offset, 3'b000};
    w_raw_wide   = {i_beat2, i_beat1} >> {i_offset, 3'b000};
    w_raw        = w_raw_wide[DATA_WIDTH-1:0];
    o_be1        = w_be_wide[3:0];
    o_be2        = w_be_wide[7:4];
    o_wdata1     = w_wdata_wide[DATA_WIDTH-1:0];
    o_wdata2     = w_wdata_wide[2*DATA_WIDTH-1:DATA_WIDTH];
    o_split      = (i_type == MEM_HALF && i_offset == 2'd3) ||
                   (i_type == MEM_WORD && i_offset != 2'd0);
    w_sext       = 1'b0;
    case (i_type)
      MEM_BYTE: begin
        w_sext = ~i_unsigned & w_raw[7];
        o_load = {{(DATA_WIDTH-8){w_sext}}, w_raw[7:0]};
      end
      MEM_HALF: begin
        w_sext = ~i_unsigned & w_raw[15];
        o_load = {{(DATA_WIDTH-16){w_sext}}, w_raw[15:0]};
      end
      default: o_load = w_raw;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, split into up to two aligned
// memory beats; FSM with registered memory-port and response outputs.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_write_i,
  input  logic [1:0]            req_type_i,
  input  logic                  req_unsigned_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  resp_valid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  busy_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [3:0]            mem_be_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  lsu_state_t            r_state;
  mem_type_t             r_type;
  logic [1:0]            r_off;
  logic                  r_write, r_unsigned, r_split;
  logic [DATA_WIDTH-1:0] r_wdata, r_beat1, r_rdata, r_mem_wdata;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [3:0]            r_mem_be;
  logic                  r_ready, r_busy, r_resp, r_mem_req, r_mem_we;

  mem_type_t             w_type;
  logic [1:0]            w_off;
  logic [DATA_WIDTH-1:0] w_wdata, w_beat1, w_wdata1, w_wdata2, w_load;
  logic [3:0]            w_be1, w_be2;
  logic                  w_split, w_idle;

  // In IDLE the aligner sees the incoming request so beat 1 can be
  // registered on the accepting edge; afterwards it sees the held fields.
  always_comb begin
    w_idle  = (r_state == S_IDLE);
    w_type  = w_idle ? norm_type(req_type_i) : r_type;
    w_off   = w_idle ? addr_i[1:0] : r_off;
    w_wdata = w_idle ? wdata_i : r_wdata;
    w_beat1 = (r_state == S_WAIT1) ? mem_rdata_i : r_beat1;
  end

  lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .i_type     (w_type),
    .i_offset   (w_off),
    .i_unsigned (r_unsigned),
    .i_wdata    (w_wdata),
    .i_beat1    (w_beat1),
    .i_beat2    (mem_rdata_i),
    .o_split    (w_split),
    .o_be1      (w_be1),
    .o_be2      (w_be2),
    .o_wdata1   (w_wdata1),
    .o_wdata2   (w_wdata2),
    .o_load     (w_load)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_type      <= MEM_WORD;
      r_off       <= '0;
      r_write     <= 1'b0;
      r_unsigned  <= 1'b0;
      r_split     <= 1'b0;
      r_wdata     <= '0;
      r_beat1     <= '0;
      r_rdata     <= '0;
      r_mem_wdata <= '0;
      r_mem_addr  <= '0;
      r_mem_be    <= '0;
      r_ready     <= 1'b1;
      r_busy      <= 1'b0;
      r_resp      <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
    end else begin
      r_resp <= 1'b0;
      case (r_state)
        S_IDLE: if (req_valid_i) begin
          r_type      <= w_type;
          r_off       <= addr_i[1:0];
          r_write     <= req_write_i;
          r_unsigned  <= req_unsigned_i;
          r_split     <= w_split;
          r_wdata     <= wdata_i;
          r_mem_req   <= 1'b1;
          r_mem_we    <= req_write_i;
          r_mem_addr  <= {addr_i[ADDR_WIDTH-1:2], 2'b00};
          r_mem_be    <= w_be1;
          r_mem_wdata <= w_wdata1;
          r_ready     <= 1'b0;
          r_busy      <= 1'b1;
          r_state     <= S_REQ1;
        end
        S_REQ1, S_REQ2: if (mem_gnt_i) begin
          r_mem_req <= 1'b0;
          r_mem_we  <= 1'b0;
          r_state   <= (r_state == S_REQ1) ? S_WAIT1 : S_WAIT2;
        end
        S_WAIT1: if (mem_rvalid_i) begin
          r_beat1 <= mem_rdata_i;
          if (r_split) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= r_write;
            r_mem_addr  <= r_mem_addr + ADDR_WIDTH'(4);
            r_mem_be    <= w_be2;
            r_mem_wdata <= w_wdata2;
            r_state     <= S_REQ2;
          end else begin
            r_rdata <= r_write ? '0 : w_load;
            r_resp  <= 1'b1;
            r_state <= S_RESP;
          end
        end
        S_WAIT2: if (mem_rvalid_i) begin
          r_rdata <= r_write ? '0 : w_load;
          r_resp  <= 1'b1;
          r_state <= S_RESP;
        end
        S_RESP: begin
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready_o  = r_ready;
  assign resp_valid_o = r_resp;
  assign rdata_o      = r_rdata;
  assign busy_o       = r_busy;
  assign mem_req_o    = r_mem_req;
  assign mem_we_o     = r_mem_we;
  assign mem_addr_o   = r_mem_addr;
  assign mem_be_o     = r_mem_be;
  assign mem_wdata_o  = r_mem_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit.
module tb_load_store_unit;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_write_i = 1'b0;
  logic [1:0]  req_type_i = 2'b00;
  logic        req_unsigned_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic        resp_valid_o;
  logic [31:0] rdata_o;
  logic        busy_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_write_i(req_write_i), .req_type_i(req_type_i),
    .req_unsigned_i(req_unsigned_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .resp_valid_o(resp_valid_o), .rdata_o(rdata_o), .busy_o(busy_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Presents a request for one cycle; returns at the first cycle after acceptance.
  task automatic issue(input logic wr, input logic [1:0] ty, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd);
    req_valid_i = 1'b1; req_write_i = wr; req_type_i = ty;
    req_unsigned_i = uns; addr_i = a; wdata_i = wd;
    @(negedge clk_i);
    req_valid_i = 1'b0;
  endtask

  // Memory responder for one beat: waits (bounded) for mem_req_o, captures the
  // beat, grants after gnt_wait cycles, returns rvalid the cycle after.
  task automatic beat(input int gnt_wait, input logic [31:0] rd,
                      output logic [31:0] a, output logic [3:0] be,
                      output logic [31:0] wd, output logic we, output logic ok);
    ok = 1'b0; a = '0; be = '0; wd = '0; we = 1'b0;
    for (int n = 0; n < 20 && mem_req_o !== 1'b1; n++) @(negedge clk_i);
    if (mem_req_o !== 1'b1) return;
    a = mem_addr_o; be = mem_be_o; wd = mem_wdata_o; we = mem_we_o;
    repeat (gnt_wait) @(negedge clk_i);
    mem_gnt_i = 1'b1;
    @(negedge clk_i);
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = rd;
    @(negedge clk_i);
    mem_rvalid_i = 1'b0; mem_rdata_i = 32'h5A5A_5A5A;
    ok = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk_i);
    total++; if (req_ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", req_ready_o); end
    total++; if ({resp_valid_o, busy_o, mem_req_o, mem_we_o} !== 4'b0000) begin bad++;
      $display("FAIL reset_ctrl got=%b exp=0000", {resp_valid_o, busy_o, mem_req_o, mem_we_o}); end
    total++; if ({mem_be_o, rdata_o, mem_addr_o, mem_wdata_o} !== '0) begin bad++;
      $display("FAIL reset_data be=%h rdata=%h addr=%h wdata=%h exp=0", mem_be_o, rdata_o, mem_addr_o, mem_wdata_o); end
    rst_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic test_load_word();
    logic [31:0] a, wd; logic [3:0] be; logic we, ok; int t0;
    t0 = cyc;
    issue(1'b0, 2'b00, 1'b0, 32'h100, '0);
    total++; if (busy_o !== 1'b1 || req_ready_o !== 1'b0) begin bad++;
      $display("FAIL lw_busy got busy=%b ready=%b exp=1/0", busy_o, req_ready_o); end
    beat(0, 32'hDEADBEEF, a, be, wd, we, ok);
    total++; if (ok !== 1'b1 || a !== 32'h100 || be !== 4'b1111 || we !== 1'b0) begin bad++;
      $display("FAIL lw_beat ok=%b addr=%h be=%b we=%b exp 1/100/1111/0", ok, a, be, we); end
    total++; if (resp_valid_o !== 1'b1 || rdata_o !== 32'hDEADBEEF) begin bad++;
      $display("FAIL lw_resp valid=%b rdata=%h exp 1/deadbeef", resp_valid_o, rdata_o); end
    total++; if (cyc - t0 !== 3) begin bad++; $display("FAIL lw_latency got=%0d exp=3", cyc - t0); end
    @(negedge clk_i);
    total++; if (resp_valid_o !== 1'b0 || req_ready_o !== 1'b1 || busy_o !== 1'b0) begin bad++;
      $display("FAIL lw_idle valid=%b ready=%b busy=%b exp 0/1/0", resp_valid_o, req_ready_o, busy_o); end
  endtask

  task automatic test_load_byte();
    logic [31:0] a, wd; logic [3:0] be; logic we, ok;
    issue(1'b0, 2'b01, 1'b0, 32'h103, '0);
    beat(0, 32'h80123456, a, be, wd, we, ok);
    total++; if (ok !== 1'b1 || a !== 32'h100 || be !== 4'b1000) begin bad++;
      $display("FAIL lbs_beat ok=%b addr=%h be=%b exp 1/100/1000", ok, a, be); end
    total++; if (resp_valid_o !== 1'b1 || rdata_o !== 32'hFFFFFF80) begin bad++;
      $display("FAIL lbs_rdata valid=%b rdata=%h exp 1/ffffff80", resp_valid_o, rdata_o); end
    @(negedge clk_i);
    issue(1'b0, 2'b01, 1'b1, 32'h103, '0);
    beat(0, 32'h80123456, a, be, wd, we, ok);
    total++; if (resp_valid_o !== 1'b1 || rdata_o !== 32'h00000080) begin bad++;
      $display("FAIL lbu_rdata valid=%b rdata=%h exp 1/00000080", resp_valid_o, rdata_o); end
    @(negedge clk_i);
    issue(1'b0, 2'b10, 1'b0, 32'h102, '0);
    beat(0, 32'h9ABC1234, a, be, wd, we, ok);
    total++; if (be !== 4'b1100 || rdata_o !== 32'hFFFF9ABC) begin bad++;
      $display("FAIL lhs_rdata be=%b rdata=%h exp 1100/ffff9abc", be, rdata_o); end
    @(negedge clk_i);
  endtask

  task automatic test_store_half();
    logic [31:0] a, wd; logic [3:0] be; logic we, ok;
    issue(1'b1, 2'b10, 1'b0, 32'h102, 32'h0000BEEF);
    beat(0, 32'h11111111, a, be, wd, we, ok);
    total++; if (ok !== 1'b1 || a !== 32'h100 || be !== 4'b1100 || wd !== 32'hBEEF0000 || we !== 1'b1) begin bad++;
      $display("FAIL sh_beat ok=%b addr=%h be=%b wdata=%h we=%b exp 1/100/1100/beef0000/1", ok, a, be, wd, we); end
    total++; if (resp_valid_o !== 1'b1 || rdata_o !== 32'h0 || mem_req_o !== 1'b0) begin bad++;
      $display("FAIL sh_resp valid=%b rdata=%h req=%b exp 1/0/0", resp_valid_o, rdata_o, mem_req_o); end
    @(negedge clk_i);
  endtask

  task automatic test_split_load();
    logic [31:0] a, wd; logic [3:0] be; logic we, ok; int t0;
    t0 = cyc;
    issue(1'b0, 2'b00, 1'b0, 32'h101, '0);
    beat(0, 32'h44332211, a, be, wd, we, ok);
    total++; if (ok !== 1'b1 || a !== 32'h100 || be !== 4'b1110 || resp_valid_o !== 1'b0) begin bad++;
      $display("FAIL lw_split_b1 ok=%b addr=%h be=%b resp=%b exp 1/100/1110/0", ok, a, be, resp_valid_o); end
    beat(0, 32'h88776655, a, be, wd, we, ok);
    total++; if (ok !== 1'b1 || a !== 32'h104 || be !== 4'b0001) begin bad++;
      $display("FAIL lw_split_b2 ok=%b addr=%h be=%b exp 1/104/0001", ok, a, be); end
    total++; if (resp_valid_o !== 1'b1 || rdata_o !== 32'h55443322 || cyc - t0 !== 5) begin bad++;
      $display("FAIL lw_split_resp valid=%b rdata=%h lat=%0d exp 1/55443322/5", resp_valid_o, rdata_o, cyc - t0); end
    @(negedge clk_i);
    // type 11 behaves as word
    issue(1'b0, 2'b11, 1'b1, 32'h102, '0);
    beat(0, 32'hAAAA0000, a, be, wd, we, ok);
    beat(0, 32'h0000BBBB, a, be, wd, we, ok);
    total++; if (resp_valid_o !== 1'b1 || rdata_o !== 32'hBBBBAAAA || be !== 4'b0011) begin bad++;
      $display("FAIL t11_resp valid=%b rdata=%h be2=%b exp 1/bbbbaaaa/0011", resp_valid_o, rdata_o, be); end
    @(negedge clk_i);
  endtask

  task automatic test_split_store_wrap();
    logic [31:0] a, wd; logic [3:0] be; logic we, ok;
    issue(1'b1, 2'b10, 1'b0, 32'hFFFFFFFF, 32'h0000ABCD);
    beat(1, 32'h0, a, be, wd, we, ok);
    total++; if (ok !== 1'b1 || a !== 32'hFFFFFFFC || be !== 4'b1000 || wd !== 32'hCD000000 || we !== 1'b1) begin bad++;
      $display("FAIL sh_wrap_b1 ok=%b addr=%h be=%b wdata=%h we=%b exp 1/fffffffc/1000/cd000000/1", ok, a, be, wd, we); end
    beat(0, 32'h0, a, be, wd, we, ok);
    total++; if (ok !== 1'b1 || a !== 32'h00000000 || be !== 4'b0001 || wd !== 32'h000000AB || we !== 1'b1) begin bad++;
      $display("FAIL sh_wrap_b2 ok=%b addr=%h be=%b wdata=%h we=%b exp 1/0/0001/000000ab/1", ok, a, be, wd, we); end
    total++; if (resp_valid_o !== 1'b1 || rdata_o !== 32'h0) begin bad++;
      $display("FAIL sh_wrap_resp valid=%b rdata=%h exp 1/0", resp_valid_o, rdata_o); end
    @(negedge clk_i);
  endtask

  task automatic test_abort();
    logic [31:0] a, wd; logic [3:0] be; logic we, ok; int held; int stray;
    held = 0; stray = 0;
    issue(1'b0, 2'b00, 1'b0, 32'h200, '0);
    repeat (5) begin
      if (mem_req_o === 1'b1 && mem_addr_o === 32'h200) held++;
      @(negedge clk_i);
    end
    total++; if (held !== 5) begin bad++; $display("FAIL abort_hold got=%0d exp=5", held); end
    mem_gnt_i = 1'b1;
    @(negedge clk_i);
    mem_gnt_i = 1'b0;
    total++; if (mem_req_o !== 1'b0 || busy_o !== 1'b1) begin bad++;
      $display("FAIL abort_wait1 req=%b busy=%b exp 0/1", mem_req_o, busy_o); end
    rst_i = 1'b1;
    #1;
    total++; if ({req_ready_o, busy_o, mem_req_o, mem_we_o, resp_valid_o, mem_be_o} !== 9'b1_0000_0000 ||
                 mem_addr_o !== '0 || rdata_o !== '0 || mem_wdata_o !== '0) begin bad++;
      $display("FAIL abort_reset ctrl=%b addr=%h rdata=%h wdata=%h exp 100000000/0/0/0",
               {req_ready_o, busy_o, mem_req_o, mem_we_o, resp_valid_o, mem_be_o}, mem_addr_o, rdata_o, mem_wdata_o); end
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hCAFEF00D;
    repeat (3) begin
      @(negedge clk_i);
      if (resp_valid_o !== 1'b0) stray++;
    end
    mem_rvalid_i = 1'b0;
    rst_i = 1'b0;
    repeat (2) begin
      @(negedge clk_i);
      if (resp_valid_o !== 1'b0) stray++;
    end
    total++; if (stray !== 0) begin bad++; $display("FAIL abort_no_resp got=%0d exp=0", stray); end
    issue(1'b0, 2'b00, 1'b0, 32'h300, '0);
    beat(0, 32'h12345678, a, be, wd, we, ok);
    total++; if (ok !== 1'b1 || a !== 32'h300 || resp_valid_o !== 1'b1 || rdata_o !== 32'h12345678) begin bad++;
      $display("FAIL abort_recover ok=%b addr=%h valid=%b rdata=%h exp 1/300/1/12345678", ok, a, resp_valid_o, rdata_o); end
    @(negedge clk_i);
  endtask

  initial begin
    test_reset();
    test_load_word();
    test_load_byte();
    test_store_half();
    test_split_load();
    test_split_store_wrap();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d", total);
    $fatal(1);
  end

endmodule
